// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath selects.
// Latency with zero-wait memory: 3 cycles (branch), 4 (R/I/LUI/AUIPC/store/JAL), 5 (load/JALR).
// Backpressure: mem_req is held until mem_ready; a watchdog traps after MAX_WAIT unanswered request cycles.
module multicycle_ctrl #(
  parameter int MAX_WAIT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic [2:0] imm_sel,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic       reg_we,
  output logic       retire,
  output logic       illegal,
  output logic       mem_timeout
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R,
    EXEC_I, ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] A_PC    = 2'd0;
  localparam logic [1:0] A_OLDPC = 2'd1;
  localparam logic [1:0] A_RS1   = 2'd2;
  localparam logic [1:0] A_ZERO  = 2'd3;

  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;
  localparam logic [1:0] B_FOUR = 2'd2;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_FUNC = 2'd2;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_MEM    = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;

  // Watchdog width keeps at least one bit so MAX_WAIT=0 (watchdog off) still elaborates.
  localparam int         WD_W    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam bit         WD_ON   = (MAX_WAIT > 0);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(MAX_WAIT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_WAIT - 1);

  state_t          state_q, state_d;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expire;
  logic            dec_illegal;

  // The cycle in which the counter would reach MAX_WAIT with no answer is the expiry cycle;
  // mem_ready in that cycle completes the access instead.
  assign wd_expire = WD_ON && mem_req && !mem_ready && (wd_cnt == WD_LAST);

  // State register; reset drops every state-decoded output immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Watchdog: counts consecutive unanswered request cycles, saturating at MAX_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   wd_cnt <= '0;
    else if (!mem_req || mem_ready) wd_cnt <= '0;
    else if (wd_cnt != WD_MAX)    wd_cnt <= wd_cnt + 1'b1;
  end

  // Sticky trap causes, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal     <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      if (dec_illegal) illegal     <= 1'b1;
      if (wd_expire)   mem_timeout <= 1'b1;
    end
  end

  // Next-state and state-decoded datapath controls.
  always_comb begin
    state_d     = state_q;
    imm_sel     = IMM_I;
    alu_src_a   = A_PC;
    alu_src_b   = B_RS2;
    alu_op      = OP_ADD;
    result_src  = RES_ALUOUT;
    adr_src     = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    reg_we      = 1'b0;
    retire      = 1'b0;
    dec_illegal = 1'b0;

    unique case (state_q)
      IDLE: state_d = FETCH;

      FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = A_PC;
        alu_src_b  = B_FOUR;
        result_src = RES_ALU;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = DECODE;
        end
      end

      // Speculatively compute old_PC + imm so a branch/JAL target sits in alu_out.
      DECODE: begin
        imm_sel   = (opcode == OP_JAL) ? IMM_J : IMM_B;
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_R:              state_d = EXEC_R;
          OP_I:              state_d = EXEC_I;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          OP_JALR:           state_d = JALR;
          OP_LUI:            state_d = LUI;
          OP_AUIPC:          state_d = AUIPC;
          default: begin
            state_d     = TRAP;
            dec_illegal = 1'b1;
          end
        endcase
      end

      // Only loads and stores reach here; opcode bit 5 separates them.
      MEMADR: begin
        imm_sel   = opcode[5] ? IMM_S : IMM_I;
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        state_d   = opcode[5] ? MEMWR : MEMRD;
      end

      MEMRD: begin
        adr_src = 1'b1;
        mem_req = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end

      MEMWB: begin
        result_src = RES_MEM;
        reg_we     = 1'b1;
        retire     = 1'b1;
        state_d    = FETCH;
      end

      MEMWR: begin
        adr_src = 1'b1;
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end

      EXEC_R: begin
        alu_src_a = A_RS1;
        alu_src_b = B_RS2;
        alu_op    = OP_FUNC;
        state_d   = ALUWB;
      end

      EXEC_I: begin
        imm_sel   = IMM_I;
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        alu_op    = OP_FUNC;
        state_d   = ALUWB;
      end

      ALUWB: begin
        result_src = RES_ALUOUT;
        reg_we     = 1'b1;
        retire     = 1'b1;
        state_d    = FETCH;
      end

      // PC loads the DECODE-computed target from alu_out when taken.
      BRANCH: begin
        alu_src_a  = A_RS1;
        alu_src_b  = B_RS2;
        alu_op     = OP_SUB;
        result_src = RES_ALUOUT;
        pc_we      = br_taken;
        retire     = 1'b1;
        state_d    = FETCH;
      end

      // rs1 + imm replaces the DECODE target, then JAL does the link and jump.
      JALR: begin
        imm_sel   = IMM_I;
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        state_d   = JAL;
      end

      // Jump to alu_out while computing old_PC + 4 for the link write in ALUWB.
      JAL: begin
        alu_src_a  = A_OLDPC;
        alu_src_b  = B_FOUR;
        result_src = RES_ALUOUT;
        pc_we      = 1'b1;
        state_d    = ALUWB;
      end

      LUI: begin
        imm_sel   = IMM_U;
        alu_src_a = A_ZERO;
        alu_src_b = B_IMM;
        state_d   = ALUWB;
      end

      AUIPC: begin
        imm_sel   = IMM_U;
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        state_d   = ALUWB;
      end

      TRAP: state_d = TRAP;

      default: state_d = IDLE;
    endcase

    if (wd_expire) state_d = TRAP;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle checks of the full output vector.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// The DUT runs with a short watchdog so timeout and its boundary are reachable.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       br_taken;
  logic       mem_ready;
  logic [2:0] imm_sel;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic       adr_src, mem_req, mem_we, ir_we, pc_we, reg_we, retire, illegal, mem_timeout;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_ctrl #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .br_taken(br_taken), .mem_ready(mem_ready),
    .imm_sel(imm_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .adr_src(adr_src), .mem_req(mem_req), .mem_we(mem_we),
    .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .retire(retire), .illegal(illegal),
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  logic [19:0] outv;
  assign outv = {imm_sel, alu_src_a, alu_src_b, alu_op, result_src, adr_src, mem_req, mem_we,
                 ir_we, pc_we, reg_we, retire, illegal, mem_timeout};

  // flags order: adr_src, mem_req, mem_we, ir_we, pc_we, reg_we, retire, illegal, mem_timeout
  function automatic logic [19:0] sg(input int imm, input int a, input int b, input int op,
                                     input int res, input logic [8:0] f);
    return {imm[2:0], a[1:0], b[1:0], op[1:0], res[1:0], f};
  endfunction

  logic [19:0] Z, F0, F1, DB, DJ, MAL, MAS, MRD, MWB, MWR, ER, AWB, BR0, BR1, JR, JL, LU, TI, TT;

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rdy, input logic bt, input logic [19:0] exp, input string tag);
    @(negedge clk);
    mem_ready = rdy;
    br_taken  = bt;
    #1;
    check(tag, outv, exp);
  endtask

  initial begin
    Z   = '0;
    F1  = sg(0, 0, 2, 0, 2, 9'b0_1_0_1_1_0_0_0_0);
    F0  = sg(0, 0, 2, 0, 2, 9'b0_1_0_0_0_0_0_0_0);
    DB  = sg(2, 1, 1, 0, 0, 9'b0);
    DJ  = sg(4, 1, 1, 0, 0, 9'b0);
    MAL = sg(0, 2, 1, 0, 0, 9'b0);
    MAS = sg(1, 2, 1, 0, 0, 9'b0);
    MRD = sg(0, 0, 0, 0, 0, 9'b1_1_0_0_0_0_0_0_0);
    MWB = sg(0, 0, 0, 0, 1, 9'b0_0_0_0_0_1_1_0_0);
    MWR = sg(0, 0, 0, 0, 0, 9'b1_1_1_0_0_0_1_0_0);
    ER  = sg(0, 2, 0, 2, 0, 9'b0);
    AWB = sg(0, 0, 0, 0, 0, 9'b0_0_0_0_0_1_1_0_0);
    BR0 = sg(0, 2, 0, 1, 0, 9'b0_0_0_0_0_0_1_0_0);
    BR1 = sg(0, 2, 0, 1, 0, 9'b0_0_0_0_1_0_1_0_0);
    JR  = sg(0, 2, 1, 0, 0, 9'b0);
    JL  = sg(0, 1, 2, 0, 0, 9'b0_0_0_0_1_0_0_0_0);
    LU  = sg(3, 3, 1, 0, 0, 9'b0);
    TI  = sg(0, 0, 0, 0, 0, 9'b0_0_0_0_0_0_0_1_0);
    TT  = sg(0, 0, 0, 0, 0, 9'b0_0_0_0_0_0_0_0_1);

    rst_n = 1'b0; opcode = 7'b0110011; br_taken = 1'b0; mem_ready = 1'b0;
    #1 check("reset", outv, Z);
    repeat (2) @(posedge clk);

    // R-type add: IDLE, FETCH, DECODE, EXEC_R, ALUWB
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1; #1 check("r_idle", outv, Z);
    step(1, 0, F1,  "r_fetch");
    step(1, 0, DB,  "r_decode");
    step(1, 0, ER,  "r_exec");
    step(1, 0, AWB, "r_aluwb");

    // Load with three wait cycles in MEMRD
    opcode = 7'b0000011;
    step(1, 0, F1,  "ld_fetch");
    step(1, 0, DB,  "ld_decode");
    step(0, 0, MAL, "ld_memadr");
    step(0, 0, MRD, "ld_wait1");
    step(0, 0, MRD, "ld_wait2");
    step(0, 0, MRD, "ld_wait3");
    step(1, 0, MRD, "ld_ready");
    step(1, 0, MWB, "ld_memwb");

    // Store, zero-wait
    opcode = 7'b0100011;
    step(1, 0, F1,  "st_fetch");
    step(1, 0, DB,  "st_decode");
    step(1, 0, MAS, "st_memadr");
    step(1, 0, MWR, "st_memwr");

    // Branch not taken, then taken
    opcode = 7'b1100011;
    step(1, 0, F1,  "bn_fetch");
    step(1, 0, DB,  "bn_decode");
    step(1, 0, BR0, "bn_branch");
    step(1, 1, F1,  "bt_fetch");
    step(1, 1, DB,  "bt_decode");
    step(1, 1, BR1, "bt_branch");

    // JALR: DECODE, JALR, JAL, ALUWB
    opcode = 7'b1100111;
    step(1, 0, F1,  "jr_fetch");
    step(1, 0, DB,  "jr_decode");
    step(1, 0, JR,  "jr_jalr");
    step(1, 0, JL,  "jr_jal");
    step(1, 0, AWB, "jr_aluwb");

    // JAL: J-type immediate in DECODE
    opcode = 7'b1101111;
    step(1, 0, F1,  "j_fetch");
    step(1, 0, DJ,  "j_decode");
    step(1, 0, JL,  "j_jal");
    step(1, 0, AWB, "j_aluwb");

    // LUI
    opcode = 7'b0110111;
    step(1, 0, F1,  "lui_fetch");
    step(1, 0, DB,  "lui_decode");
    step(1, 0, LU,  "lui_exec");
    step(1, 0, AWB, "lui_aluwb");

    // Illegal opcode: TRAP holds with all strobes low regardless of inputs
    opcode = 7'b1111111;
    step(1, 0, F1, "ill_fetch");
    step(1, 0, DB, "ill_decode");
    for (int i = 0; i < 100; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), TI, "ill_trap");

    @(negedge clk); rst_n = 1'b0; #1 check("ill_rst", outv, Z);
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b0; #1 check("ill_idle", outv, Z);

    // Watchdog boundary: ready on the fourth wait cycle still wins
    opcode = 7'b0110011;
    step(0, 0, F0, "wdb_wait1");
    step(0, 0, F0, "wdb_wait2");
    step(0, 0, F0, "wdb_wait3");
    step(1, 0, F1, "wdb_ready");
    step(1, 0, DB, "wdb_decode");
    step(1, 0, ER, "wdb_exec");
    step(0, 0, AWB, "wdb_aluwb");

    // Watchdog expiry: four unanswered FETCH cycles then TRAP with mem_timeout
    step(0, 0, F0, "wd_wait1");
    step(0, 0, F0, "wd_wait2");
    step(0, 0, F0, "wd_wait3");
    step(0, 0, F0, "wd_wait4");
    step(0, 0, TT, "wd_trap");
    step(1, 0, TT, "wd_trap_hold");

    // Reset asserted mid-FETCH drops mem_req in the same cycle
    @(negedge clk); rst_n = 1'b0; #1 check("wd_rst", outv, Z);
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b0; #1 check("mid_idle", outv, Z);
    step(0, 0, F0, "mid_fetch");
    @(posedge clk); #2 rst_n = 1'b0; #1 check("mid_rst", outv, Z);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
